// File: rtl/bram_arbiter.sv
// Round-robin arbiter that lets two requesters (fetch, data) share one memory port, one transaction at a time.
// Defining BRAM_ARB_TIMEOUT_EN adds a BUSY watchdog that completes a stuck transaction with an error.
module bram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              aresetn,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [3:0]        r0_strb,
  output logic              r0_ack,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [3:0]        r1_strb,
  output logic              r1_ack,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_strb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [31:0]       wdata_vec [2];
  logic [3:0]        strb_vec  [2];

  logic              grant_reg;
  logic              last_grant_reg;
  logic              pick;
  logic              timeout_hit;
  logic              complete;

  logic              cmd_we_reg;
  logic [ADDR_W-1:0] cmd_addr_reg;
  logic [31:0]       cmd_wdata_reg;
  logic [3:0]        cmd_strb_reg;

  logic [1:0][31:0]  rdata_reg;
  logic [1:0]        ack_vec;
  logic [1:0]        err_vec;

  assign req_vec      = {r1_req, r0_req};
  assign we_vec       = {r1_we, r0_we};
  assign addr_vec[0]  = r0_addr;
  assign addr_vec[1]  = r1_addr;
  assign wdata_vec[0] = r0_wdata;
  assign wdata_vec[1] = r1_wdata;
  assign strb_vec[0]  = r0_strb;
  assign strb_vec[1]  = r1_strb;

  // Contended: whoever was not served last wins; otherwise the lone requester wins.
  assign pick     = (&req_vec) ? ~last_grant_reg : req_vec[1];
  assign complete = (state_reg == BUSY) && (mem_done || timeout_hit);

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    ack_vec    = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|req_vec) state_next = BUSY;
      end
      BUSY: begin
        mem_req = 1'b1;
        if (mem_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        ack_vec[grant_reg] = 1'b1;
        state_next         = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cmd_we_reg     <= 1'b0;
      cmd_addr_reg   <= '0;
      cmd_wdata_reg  <= '0;
      cmd_strb_reg   <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && (|req_vec)) begin
        grant_reg     <= pick;
        cmd_we_reg    <= we_vec[pick];
        cmd_addr_reg  <= addr_vec[pick];
        cmd_wdata_reg <= wdata_vec[pick];
        cmd_strb_reg  <= strb_vec[pick];
      end
      // Writes and timed-out transactions return zero data.
      if (complete) begin
        rdata_reg[grant_reg] <= (mem_done && !cmd_we_reg) ? mem_rdata : 32'h0;
      end
      if (state_reg == RESP) begin
        last_grant_reg <= grant_reg;
      end
    end
  end

`ifdef BRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] busy_cnt_reg;
  logic             err_reg;

  // busy_cnt_reg holds the number of BUSY cycles already elapsed; mem_done wins a tie with the limit.
  assign timeout_hit = (state_reg == BUSY) && (busy_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign err_vec     = ack_vec & {2{err_reg}};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      busy_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg != BUSY) begin
        busy_cnt_reg <= '0;
      end else if (!complete) begin
        busy_cnt_reg <= busy_cnt_reg + CNT_W'(1);
      end
      if (complete) begin
        err_reg <= !mem_done;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_vec     = 2'b00;
`endif

  assign mem_we    = cmd_we_reg;
  assign mem_addr  = cmd_addr_reg;
  assign mem_wdata = cmd_wdata_reg;
  assign mem_strb  = cmd_strb_reg;

  assign r0_ack   = ack_vec[0];
  assign r1_ack   = ack_vec[1];
  assign r0_rdata = rdata_reg[0];
  assign r1_rdata = rdata_reg[1];
  assign r0_err   = err_vec[0];
  assign r1_err   = err_vec[1];

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed scoreboard bench for bram_arbiter: one bus-functional process plays both requesters and the memory.
// With BRAM_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT=16 and the watchdog cases run too.
module tb_bram_arbiter;
`ifdef BRAM_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        aresetn;
  logic [1:0]  req_d;
  logic [1:0]  we_d;
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic [3:0]  strb_d  [2];
  logic        r0_ack, r1_ack, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_strb;

  bram_arbiter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .aresetn(aresetn),
    .r0_req(req_d[0]), .r0_we(we_d[0]), .r0_addr(addr_d[0]), .r0_wdata(wdata_d[0]), .r0_strb(strb_d[0]),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(req_d[1]), .r1_we(we_d[1]), .r1_addr(addr_d[1]), .r1_wdata(wdata_d[1]), .r1_strb(strb_d[1]),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t sb[$];
  txn_t pend0[$];
  txn_t pend1[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_count = 0;
  int start_cyc [2];
  int ack_cyc   [2];
  bit auto_done;
  int stall_cycles;
  bit stray_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no end expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  function automatic bit pend_peek(input int id, output txn_t t);
    if (id == 0 && pend0.size() != 0) begin t = pend0[0]; return 1'b1; end
    if (id == 1 && pend1.size() != 0) begin t = pend1[0]; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic pend_pop(input int id);
    if (id == 0 && pend0.size() != 0) void'(pend0.pop_front());
    if (id == 1 && pend1.size() != 0) void'(pend1.pop_front());
  endtask

  // Expected response is queued in the grant order the caller asserts.
  task automatic issue(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic err);
    txn_t t;
    t.id = id; t.we = we; t.addr = addr; t.wdata = wdata; t.strb = strb; t.err = err;
    t.rdata = (we || err) ? 32'h0 : mem_val(addr);
    sb.push_back(t);
    if (id == 0) pend0.push_back(t); else pend1.push_back(t);
    $display("[TB] issue r%0d we=%0d addr=%h wdata=%h strb=%h", id, we, addr, wdata, strb);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (sb.size() != 0 && n < 500);
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  // Requesters, memory responder and response monitor in one process.
  initial begin
    txn_t t;
    int busy_n;
    int wait_n [2];
    bit in_flight [2];
    logic [31:0] hold_exp [2];
    logic [127:0] snap;
    logic a, e;
    logic [31:0] rd;
    busy_n = 0;
    wait_n = '{0, 0};
    in_flight = '{1'b0, 1'b0};
    hold_exp = '{32'h0, 32'h0};
    snap = '0;
    req_d = 2'b00; we_d = 2'b00;
    addr_d = '{32'h0, 32'h0}; wdata_d = '{32'h0, 32'h0}; strb_d = '{4'h0, 4'h0};
    mem_done = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        in_flight = '{1'b0, 1'b0};
        hold_exp = '{32'h0, 32'h0};
        busy_n = 0;
        mem_done = 1'b0;
      end else begin
        if (r0_ack || r1_ack) check("ack_exclusive", r0_ack & r1_ack, 1'b0);
        for (int id = 0; id < 2; id++) begin
          a  = (id == 0) ? r0_ack : r1_ack;
          e  = (id == 0) ? r0_err : r1_err;
          rd = (id == 0) ? r0_rdata : r1_rdata;
          if (a) begin
            ack_count++;
            ack_cyc[id] = cyc;
            check("ack_expected", (sb.size() != 0) && in_flight[id], 1'b1);
            if (sb.size() != 0) begin
              t = sb.pop_front();
              check("ack_id", id, t.id);
              check("ack_rdata", rd, t.rdata);
              check("ack_err", e, t.err);
              hold_exp[id] = t.rdata;
              $display("[TB] ack r%0d rdata=%h err=%0d cyc=%0d", id, rd, e, cyc);
            end
            pend_pop(id);
            in_flight[id] = 1'b0;
          end else begin
            check("rdata_hold", rd, hold_exp[id]);
            check("err_idle", e, 1'b0);
            if (in_flight[id]) begin
              wait_n[id]++;
              if (wait_n[id] > 3000) begin
                check("ack_wait_cycles", wait_n[id], 0);
                pend_pop(id);
                in_flight[id] = 1'b0;
              end
            end
          end
        end
        if (mem_req) begin
          if (busy_n == 0) begin
            snap = {mem_we, mem_addr, mem_wdata, mem_strb};
            check("mem_cmd_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) check("mem_cmd", snap, {sb[0].we, sb[0].addr, sb[0].wdata, sb[0].strb});
          end else begin
            check("mem_cmd_stable", {mem_we, mem_addr, mem_wdata, mem_strb}, snap);
          end
          if (auto_done && busy_n == stall_cycles) begin
            mem_done = 1'b1;
            mem_rdata = mem_val(mem_addr);
          end else begin
            mem_done = 1'b0;
            mem_rdata = $urandom;
          end
          busy_n++;
        end else begin
          busy_n = 0;
          mem_done = stray_done;
          mem_rdata = $urandom;
        end
      end
      @(posedge clk);
      #1;
      for (int id = 0; id < 2; id++) begin
        if (!aresetn) begin
          req_d[id] = 1'b0;
        end else if (!in_flight[id]) begin
          if (pend_peek(id, t)) begin
            req_d[id] = 1'b1; we_d[id] = t.we; addr_d[id] = t.addr;
            wdata_d[id] = t.wdata; strb_d[id] = t.strb;
            in_flight[id] = 1'b1; wait_n[id] = 0; start_cyc[id] = cyc;
          end else begin
            req_d[id] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int acks_before;
    int n;
    aresetn = 1'b0;
    auto_done = 1'b1;
    stall_cycles = 0;
    stray_done = 1'b0;

    // Reset values, sampled while reset is held and again just after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_strb", mem_strb, 4'h0);
    check("rst_r0_ack", r0_ack, 1'b0);
    check("rst_r1_ack", r1_ack, 1'b0);
    check("rst_r0_rdata", r0_rdata, 32'h0);
    check("rst_r1_rdata", r1_rdata, 32'h0);
    check("rst_r0_err", r0_err, 1'b0);
    check("rst_r1_err", r1_err, 1'b0);
    aresetn = 1'b1;
    @(negedge clk);
    #2;
    check("post_rst_mem_req", mem_req, 1'b0);

    // Single read with minimum latency.
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
    wait_idle("single_read");
    check("single_read_latency", ack_cyc[0] - start_cyc[0] + 1, 3);
    repeat (3) @(posedge clk);
    #1 check("single_read_hold", r0_rdata, 32'hDEADBEEF);

    // Simultaneous requests right after reset: r0 first, then the r1 write.
    pulse_reset();
    @(negedge clk);
    issue(0, 1'b0, 32'h0, 32'hA5A5A5A5, 4'h3, 1'b0);
    issue(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
    wait_idle("simultaneous");
    check("simul_r1_after_r0", ack_cyc[1] > ack_cyc[0], 1'b1);

    // Sustained contention alternates grants.
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'h200 + 32'(i * 4), 32'(i), 4'hF, 1'b0);
      issue(1, i[0], 32'h300 + 32'(i * 4), 32'h11111111 * 32'(i + 1), 4'(1 << i), 1'b0);
    end
    wait_idle("contention");

    // Memory stall of 20 cycles.
    stall_cycles = 20;
    issue(1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0);
    wait_idle("stall");
    check("stall_latency", ack_cyc[1] - start_cyc[1] + 1, 23);
    stall_cycles = 0;

    // mem_done while idle must not produce any response.
    acks_before = ack_count;
    stray_done = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #2 check("stray_done_no_req", mem_req, 1'b0);
    end
    stray_done = 1'b0;
    check("stray_done_no_ack", ack_count, acks_before);

    // Reset while BUSY aborts without an ack; the next r1 request then completes.
    auto_done = 1'b0;
    issue(0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 50);
    check("abort_reached_busy", mem_req, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    check("abort_mem_req_async", mem_req, 1'b0);
    check("abort_no_r0_ack", r0_ack, 1'b0);
    acks_before = ack_count;
    repeat (3) @(posedge clk);
    sb.delete();
    pend0.delete();
    pend1.delete();
    #1 aresetn = 1'b1;
    auto_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("abort_no_ack", ack_count, acks_before);
    issue(1, 1'b1, 32'h44, 32'hCAFEF00D, 4'h5, 1'b0);
    wait_idle("after_abort");
    check("after_abort_latency", ack_cyc[1] - start_cyc[1] + 1, 3);

`ifdef BRAM_ARB_TIMEOUT_EN
    // Watchdog: no mem_done at all, then mem_done exactly on the 16th BUSY cycle.
    auto_done = 1'b0;
    issue(0, 1'b0, 32'h600, 32'h0, 4'hF, 1'b1);
    wait_idle("timeout");
    check("timeout_latency", ack_cyc[0] - start_cyc[0] + 1, 18);
    auto_done = 1'b1;
    stall_cycles = 15;
    issue(1, 1'b0, 32'h604, 32'h0, 4'hF, 1'b0);
    wait_idle("timeout_tie");
    check("timeout_tie_latency", ack_cyc[1] - start_cyc[1] + 1, 18);
    stall_cycles = 0;
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, requester and memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for mem_done (used only with BRAM_ARB_TIMEOUT_EN).
REQ-003 SHALL have ports: clk in 1, rising-edge clock; aresetn in 1, asynchronous active-low reset.
REQ-004 SHALL have, per requester n in {0 = instruction fetch, 1 = data}: rN_req in 1, request; rN_we in 1, write; rN_addr in ADDR_W, byte address; rN_wdata in 32, write data; rN_strb in 4, byte strobes.
REQ-005 SHALL have, per requester: rN_ack out 1, one-cycle completion pulse; rN_rdata out 32, read data, valid with rN_ack; rN_err out 1, error flag, valid with rN_ack.
REQ-006 SHALL have memory-side ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out 32; mem_strb out 4; mem_rdata in 32; mem_done in 1, one-cycle completion from the AXI bridge.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-008 In IDLE with any rN_req high, SHALL grant one requester, register its we/addr/wdata/strb, and enter BUSY on the next edge.
REQ-009 Arbitration SHALL be round-robin: last_grant register, reset 1; when both requests are high, the requester not equal to last_grant wins; a single request wins unconditionally.
REQ-010 In BUSY, mem_req SHALL be high and mem_* SHALL drive the registered command, constant until mem_done.
REQ-011 On mem_done in BUSY, SHALL capture mem_rdata (reads only; writes return 0) and enter RESP.
REQ-012 In RESP, SHALL pulse rN_ack of the granted requester for exactly one cycle, update last_grant, and return to IDLE.
REQ-013 Minimum latency SHALL be 3 cycles from rN_req sampled high to rN_ack (mem_done in the first BUSY cycle).
REQ-014 A requester SHALL hold rN_req and its command stable until its rN_ack; it may reassert in the cycle after ack, and the request is then arbitrated in the following IDLE.
REQ-015 A request deasserted before grant SHALL be ignored; rN_req changes during BUSY/RESP SHALL NOT affect the transaction in flight.
REQ-016 mem_done outside BUSY SHALL be ignored.
REQ-017 rN_ack SHALL never be high for both requesters in the same cycle.
REQ-018 rN_rdata SHALL hold its last value between acks; rN_err SHALL be 0 except as defined under Configuration.

Reset
REQ-019 On aresetn low, the block SHALL immediately enter IDLE regardless of clock, aborting any transaction in flight without an ack.
REQ-020 Reset values SHALL be: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_strb 0, rN_ack 0, rN_rdata 0, rN_err 0, last_grant 1.
REQ-021 The first arbitration after reset SHALL favour requester 0 when both request.

Configuration
REQ-022 With macro BRAM_ARB_TIMEOUT_EN defined, the block SHALL count BUSY cycles; when the count reaches TIMEOUT without mem_done, it SHALL drop mem_req, enter RESP, and ack with rN_err=1 and rN_rdata=0.
REQ-023 mem_done in the same cycle the timeout is reached SHALL take priority: normal completion, err=0.
REQ-024 Without BRAM_ARB_TIMEOUT_EN, no counter SHALL be built, BUSY SHALL wait indefinitely, and rN_err SHALL be tied 0.

Verification
REQ-025 Single read: r0 req addr 0x100, mem_done with mem_rdata 0xDEADBEEF one cycle later -> r0_ack pulses once, r0_rdata=0xDEADBEEF, latency 3.
REQ-026 Simultaneous requests after reset: r0 read 0x0, r1 write 0x40 data 0x12345678 strb 0xF -> r0 served first, then r1; mem_we=1, mem_wdata=0x12345678 on the second grant.
REQ-027 Continuous contention: both requests held high for 8 transactions -> grants alternate 0,1,0,1...; no double ack.
REQ-028 Reset mid-BUSY: assert aresetn low while mem_req=1 -> mem_req drops asynchronously, no ack; after release, a new r1 request completes normally.
REQ-029 Stall: mem_done withheld 20 cycles -> mem_* stable throughout, ack on cycle after mem_done.
REQ-030 With BRAM_ARB_TIMEOUT_EN and TIMEOUT=16: mem_done never arrives -> ack with err=1, rdata=0 after 16 BUSY cycles; mem_done arriving on cycle 16 -> err=0.
